spi_ram_ctrl: RTL and testbench

Single-port RAM with a command decoder. It sits directly downstream of the SPI slave. It consumes each 10-bit `rx_data` word framed by `rx_valid` and executes one of four commands: write address, write data, read address, read data. Read results return to the SPI slave on `dout`/`tx_valid` (the slave's `tx_data`/`tx_valid`), which shifts them out on MISO.

---
 rtl/spi_ram_ctrl.sv | 103 ++++++++++
 tb/tb_spi_ram_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind an SPI slave: decodes 10-bit words into
// write-address / write-data / read-address / read-data operations.
`timescale 1ns/1ps

module spi_ram_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       rd_err
);

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_t;

    if (ADDR_SIZE < 1 || ADDR_SIZE > 8 || MEM_DEPTH != (1 << ADDR_SIZE)) begin : g_param_check
        $error("spi_ram_ctrl: ADDR_SIZE must be 1..8 and MEM_DEPTH must equal 2**ADDR_SIZE");
    end

    logic [7:0]           mem [0:MEM_DEPTH-1];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 rd_armed;
    logic                 rx_valid_d;

    opcode_t op;
    logic    accept;
    logic    wr_addr_en;
    logic    wr_data_en;
    logic    rd_addr_en;
    logic    rd_data_en;
    logic    rd_err_set;

    assign op = opcode_t'(din[9:8]);

    // One command per rx_valid rising edge; a word seen while rst is high is dropped.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        accept     = rx_valid && !rx_valid_d && !rst;
        wr_addr_en = 1'b0;
        wr_data_en = 1'b0;
        rd_addr_en = 1'b0;
        rd_data_en = 1'b0;
        rd_err_set = 1'b0;
        if (accept) begin
            unique case (op)
                OP_WR_ADDR: wr_addr_en = 1'b1;
                OP_WR_DATA: wr_data_en = 1'b1;
                OP_RD_ADDR: rd_addr_en = 1'b1;
                OP_RD_DATA: begin
                    rd_data_en = rd_armed;
                    rd_err_set = !rd_armed;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid_d <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            rd_armed   <= 1'b0;
            dout       <= 8'h00;
            tx_valid   <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rx_valid_d <= rx_valid;
            tx_valid   <= rd_data_en;
            rd_err     <= rd_err_set;

            if (wr_addr_en)
                wr_addr <= din[ADDR_SIZE-1:0];
            else if (wr_data_en)
                wr_addr <= wr_addr + ADDR_SIZE'(1);

            if (rd_addr_en) begin
                rd_addr  <= din[ADDR_SIZE-1:0];
                rd_armed <= 1'b1;
            end else if (rd_data_en) begin
                rd_addr <= rd_addr + ADDR_SIZE'(1);
                dout    <= mem[rd_addr];
            end
        end
    end

    // NOTE: the memory array is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_data_en)
            mem[wr_addr] <= din[7:0];
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Randomized self-checking bench for spi_ram_ctrl against a command-level model.
`timescale 1ns/1ps

module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] dout;
    logic       tx_valid;
    logic       rd_err;

    spi_ram_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(256)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .rd_err   (rd_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Command-level model: applied once per issued word at its acceptance edge.
    logic [7:0] m_mem [256];
    logic [7:0] m_wr, m_rd;
    bit         m_armed;
    logic [7:0] exp_dout;
    bit         exp_tx, exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wr = 8'h00; m_rd = 8'h00; m_armed = 1'b0;
        exp_dout = 8'h00; exp_tx = 1'b0; exp_err = 1'b0;
    endtask

    task automatic model(input logic [9:0] w);
        exp_tx  = 1'b0;
        exp_err = 1'b0;
        case (w[9:8])
            2'b00: m_wr = w[7:0];
            2'b01: begin m_mem[m_wr] = w[7:0]; m_wr = m_wr + 8'd1; end
            2'b10: begin m_rd = w[7:0]; m_armed = 1'b1; end
            default: begin
                if (m_armed) begin
                    exp_dout = m_mem[m_rd];
                    exp_tx   = 1'b1;
                    m_rd     = m_rd + 8'd1;
                end else begin
                    exp_err = 1'b1;
                end
            end
        endcase
    endtask

    // Every posedge outside an acceptance edge ends any one-cycle pulse.
    task automatic tick();
        @(posedge clk);
        exp_tx  = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic issue(input logic [9:0] w);
        @(negedge clk);
        din = w;
        rx_valid = 1'b1;
        @(posedge clk);
        model(w);
    endtask

    task automatic finish_cmd(input int hold, input int gap);
        repeat (hold - 1) tick();
        @(negedge clk);
        rx_valid = 1'b0;
        din = 10'($urandom);
        repeat (gap) tick();
    endtask

    task automatic send(input logic [9:0] w, input int hold = 1, input int gap = 1);
        issue(w);
        finish_cmd(hold, gap);
    endtask

    // Asynchronous reset between edges; optionally leaves rx_valid high across release.
    task automatic do_reset(input bit with_word, input logic [9:0] w);
        @(negedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_rd_err", 32'(rd_err), 32'h0);
        if (with_word) begin
            din = w;
            rx_valid = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        if (with_word) begin
            @(posedge clk);
            model(w);
            finish_cmd(1, 1);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("dout", 32'(dout), 32'(exp_dout));
            check("tx_valid", 32'(tx_valid), 32'(exp_tx));
            check("rd_err", 32'(rd_err), 32'(exp_err));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;

        // Read-data with no address armed: error pulse, no data.
        issue(10'h300);
        #1;
        check("noaddr_rd_err", 32'(rd_err), 32'h1);
        check("noaddr_tx_valid", 32'(tx_valid), 32'h0);
        check("noaddr_dout", 32'(dout), 32'h0);
        finish_cmd(1, 2);

        // Fill all of memory so every later read has a known expectation.
        send(10'h000);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = (i == 4) ? 8'h5A : 8'($urandom);
            send({2'b01, v}, $urandom_range(1, 2), $urandom_range(1, 2));
        end

        // Held rx_valid writes exactly once.
        send(10'h003);
        send(10'h1A5, 10, 1);
        send(10'h203);
        issue(10'h300);
        #1;
        check("held_mem3", 32'(dout), 32'hA5);
        finish_cmd(1, 1);
        issue(10'h300);
        #1;
        check("held_mem4_untouched", 32'(dout), 32'h5A);
        finish_cmd(1, 2);

        // Write then read.
        send(10'h005);
        send(10'h1A5);
        send(10'h205);
        issue(10'h300);
        #1;
        check("wr_rd_dout", 32'(dout), 32'hA5);
        check("wr_rd_tx_valid", 32'(tx_valid), 32'h1);
        finish_cmd(1, 2);

        // Auto-increment wrap from 0xFF to 0x00, back-to-back pulses.
        send(10'h0FF);
        send(10'h111);
        send(10'h122);
        send(10'h2FF);
        issue(10'h300);
        #1;
        check("wrap_first", 32'(dout), 32'h11);
        finish_cmd(1, 1);
        issue(10'h300);
        #1;
        check("wrap_second", 32'(dout), 32'h22);
        check("wrap_tx_valid", 32'(tx_valid), 32'h1);
        finish_cmd(1, 2);

        // Reset mid-sequence clears the armed flag but keeps memory.
        send(10'h007);
        send(10'h13C);
        send(10'h207);
        do_reset(1'b0, 10'h000);
        issue(10'h300);
        #1;
        check("rstmid_rd_err", 32'(rd_err), 32'h1);
        check("rstmid_tx_valid", 32'(tx_valid), 32'h0);
        finish_cmd(1, 1);
        send(10'h207);
        issue(10'h300);
        #1;
        check("rstmid_mem_kept", 32'(dout), 32'h3C);
        finish_cmd(1, 2);

        // Word already high at reset release is accepted on the first clock.
        do_reset(1'b1, 10'h209);
        issue(10'h300);
        #1;
        check("rel_word_accepted_tx", 32'(tx_valid), 32'h1);
        finish_cmd(1, 1);

        // Randomized command stream with occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic [9:0] w;
            w = 10'($urandom);
            if ($urandom_range(0, 49) == 0)
                do_reset($urandom_range(0, 1) == 1, w);
            else
                send(w, $urandom_range(1, 4), $urandom_range(1, 3));
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
